// File: rtl/rx_fifo_wr_pkg.sv
// Shared tag encoding and FSM states for the RX FIFO write-side packer.
package rx_fifo_wr_pkg;

    localparam logic [1:0] TAG_DATA  = 2'b00;
    localparam logic [1:0] TAG_FIRST = 2'b01;
    localparam logic [1:0] TAG_END   = 2'b10;
    localparam logic [1:0] TAG_DISC  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StPack,
        StLastWr,
        StEndWr,
        StDrop,
        StDiscWr
    } wr_state_e;

endpackage

// File: rtl/rx_fifo_write_ctrl.sv
// Packs the RX byte stream into tagged 32-bit little-endian words and appends one END or
// DISCARD status word per frame, through a single registered staging slot.
module rx_fifo_write_ctrl
    import rx_fifo_wr_pkg::*;
#(
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned DROP_WIDTH = 8
) (
    input  logic                  wrClk,
    input  logic                  wrHardReset_n,
    input  logic                  wrFlush,
    input  logic                  rxStart,
    input  logic [7:0]            rxData,
    input  logic                  rxDataValid,
    input  logic                  rxEnd,
    input  logic                  rxAbort,
    input  logic [15:0]           rxStatus,
    input  logic                  fifoFull,
    output logic                  fifoWrite,
    output logic [31:0]           fifoWrData,
    output logic [1:0]            fifoWrTag,
    output logic                  rxBusy,
    output logic                  rxOverflow,
    output logic [DROP_WIDTH-1:0] rxDropCnt
);

    localparam int unsigned DropSumW = DROP_WIDTH + 1;

    wr_state_e             state;
    logic                  wr_pending;
    logic [23:0]           asm_q;
    logic [1:0]            lane;
    logic [LEN_WIDTH-1:0]  byte_cnt;
    logic                  first_flag;
    logic [15:0]           status_q;

    logic                  slot_free;
    logic                  late_start;
    logic                  disc_done;
    logic                  overflow_now;
    logic [1:0]            lane_nxt;
    logic [1:0]            drop_inc;
    logic [DROP_WIDTH:0]   drop_sum;
    logic [DROP_WIDTH-1:0] drop_nxt;
    logic [LEN_WIDTH-1:0]  byte_cnt_inc;
    logic [15:0]           len_field;

    always_comb begin
        fifoWrite    = wr_pending & ~fifoFull;
        // The slot counts as free when its current occupant leaves this very cycle.
        slot_free    = ~wr_pending | fifoWrite;
        rxBusy       = (state != StIdle);
        late_start   = rxStart & (state != StIdle);
        disc_done    = fifoWrite & (fifoWrTag == TAG_DISC);
        overflow_now = rxDataValid & (lane == 2'd3) & ~slot_free;
        lane_nxt     = rxDataValid ? lane + 2'd1 : lane;
        drop_inc     = {1'b0, late_start} + {1'b0, disc_done};
        drop_sum     = {1'b0, rxDropCnt} + DropSumW'(drop_inc);
        drop_nxt     = drop_sum[DROP_WIDTH] ? {DROP_WIDTH{1'b1}} : drop_sum[DROP_WIDTH-1:0];
        byte_cnt_inc = (&byte_cnt) ? byte_cnt : byte_cnt + 1'b1;
        len_field    = 16'(byte_cnt);
    end

    always_ff @(posedge wrClk or negedge wrHardReset_n) begin
        if (!wrHardReset_n) begin
            state      <= StIdle;
            wr_pending <= 1'b0;
            fifoWrData <= '0;
            fifoWrTag  <= TAG_DATA;
            rxOverflow <= 1'b0;
            rxDropCnt  <= '0;
            byte_cnt   <= '0;
            lane       <= '0;
            first_flag <= 1'b0;
            asm_q      <= '0;
            status_q   <= '0;
        end else if (wrFlush) begin
            state      <= StIdle;
            wr_pending <= 1'b0;
            fifoWrData <= '0;
            fifoWrTag  <= TAG_DATA;
            rxOverflow <= 1'b0;
            rxDropCnt  <= '0;
            byte_cnt   <= '0;
            lane       <= '0;
            first_flag <= 1'b0;
            asm_q      <= '0;
            status_q   <= '0;
        end else begin
            if (fifoWrite) wr_pending <= 1'b0;
            rxDropCnt <= drop_nxt;

            unique case (state)
                StIdle: begin
                    if (rxStart) begin
                        state      <= StPack;
                        byte_cnt   <= '0;
                        lane       <= '0;
                        first_flag <= 1'b1;
                        asm_q      <= '0;
                    end
                end

                StPack: begin
                    if (rxStart || rxAbort) begin
                        state <= StDiscWr;
                    end else begin
                        if (rxDataValid) begin
                            byte_cnt <= byte_cnt_inc;
                            lane     <= lane + 2'd1;
                            unique case (lane)
                                2'd0: asm_q[7:0]   <= rxData;
                                2'd1: asm_q[15:8]  <= rxData;
                                2'd2: asm_q[23:16] <= rxData;
                                2'd3: begin
                                    if (slot_free) begin
                                        wr_pending <= 1'b1;
                                        fifoWrData <= {rxData, asm_q};
                                        fifoWrTag  <= first_flag ? TAG_FIRST : TAG_DATA;
                                        first_flag <= 1'b0;
                                        asm_q      <= '0;
                                    end else begin
                                        rxOverflow <= 1'b1;
                                    end
                                end
                            endcase
                        end
                        if (overflow_now) begin
                            state <= rxEnd ? StDiscWr : StDrop;
                        end else if (rxEnd) begin
                            status_q <= rxStatus;
                            state    <= (lane_nxt != 2'd0) ? StLastWr : StEndWr;
                        end
                    end
                end

                StLastWr: begin
                    // Upper lanes are already zero: asm_q is cleared whenever a word is staged.
                    if (slot_free) begin
                        wr_pending <= 1'b1;
                        fifoWrData <= {8'h00, asm_q};
                        fifoWrTag  <= first_flag ? TAG_FIRST : TAG_DATA;
                        first_flag <= 1'b0;
                        state      <= StEndWr;
                    end
                end

                StEndWr: begin
                    if (wr_pending && fifoWrTag == TAG_END) begin
                        if (fifoWrite) state <= StIdle;
                    end else if (slot_free) begin
                        wr_pending <= 1'b1;
                        fifoWrData <= {status_q, len_field};
                        fifoWrTag  <= TAG_END;
                    end
                end

                StDrop: begin
                    if (rxDataValid) byte_cnt <= byte_cnt_inc;
                    if (rxEnd || rxAbort || rxStart) state <= StDiscWr;
                end

                StDiscWr: begin
                    if (wr_pending && fifoWrTag == TAG_DISC) begin
                        if (fifoWrite) state <= StIdle;
                    end else if (slot_free) begin
                        wr_pending <= 1'b1;
                        fifoWrData <= {16'h0000, len_field};
                        fifoWrTag  <= TAG_DISC;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_fifo_write_ctrl.sv
// Directed scenarios plus randomized frames checked against a frame-level model of the
// expected FIFO word stream.
module tb_rx_fifo_write_ctrl;

    logic        wrClk = 1'b0;
    logic        wrHardReset_n = 1'b0;
    logic        wrFlush = 1'b0;
    logic        rxStart = 1'b0;
    logic [7:0]  rxData = 8'h00;
    logic        rxDataValid = 1'b0;
    logic        rxEnd = 1'b0;
    logic        rxAbort = 1'b0;
    logic [15:0] rxStatus = 16'h0000;
    logic        fifoFull = 1'b0;
    logic        fifoWrite;
    logic [31:0] fifoWrData;
    logic [1:0]  fifoWrTag;
    logic        rxBusy;
    logic        rxOverflow;
    logic [7:0]  rxDropCnt;

    rx_fifo_write_ctrl #(.LEN_WIDTH(16), .DROP_WIDTH(8)) dut (
        .wrClk        (wrClk),
        .wrHardReset_n(wrHardReset_n),
        .wrFlush      (wrFlush),
        .rxStart      (rxStart),
        .rxData       (rxData),
        .rxDataValid  (rxDataValid),
        .rxEnd        (rxEnd),
        .rxAbort      (rxAbort),
        .rxStatus     (rxStatus),
        .fifoFull     (fifoFull),
        .fifoWrite    (fifoWrite),
        .fifoWrData   (fifoWrData),
        .fifoWrTag    (fifoWrTag),
        .rxBusy       (rxBusy),
        .rxOverflow   (rxOverflow),
        .rxDropCnt    (rxDropCnt)
    );

    always #5 wrClk = ~wrClk;

    int          vecs = 0;
    int          errs = 0;
    logic [33:0] got_q[$];
    logic [33:0] exp_q[$];
    logic [7:0]  fb[16];
    logic [15:0] cur_status;
    bit          rnd_full = 1'b0;
    int          full_run = 0;
    int          exp_drop = 0;

    always @(negedge wrClk) if (wrHardReset_n && fifoWrite) got_q.push_back({fifoWrTag, fifoWrData});

    // Short random backpressure bursts, never long enough to lose a word.
    initial begin
        forever begin
            @(posedge wrClk);
            #1;
            if (rnd_full) begin
                if (full_run < 2 && $urandom_range(0, 3) == 0) begin
                    fifoFull = 1'b1;
                    full_run++;
                end else begin
                    fifoFull = 1'b0;
                    full_run = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vecs++;
        assert (obs === expv)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge wrClk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (rxBusy !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, 64'(rxBusy), 64'd0);
        step();
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Frame-level model: every completed 4-byte group becomes a word, a good frame also
    // flushes its tail, and the frame closes with one END or DISCARD word.
    task automatic build_expected(input int n, input bit good, input logic [15:0] st);
        int          full;
        logic [31:0] w;
        full = n / 4;
        for (int k = 0; k < full; k++) begin
            w = {fb[4*k+3], fb[4*k+2], fb[4*k+1], fb[4*k]};
            exp_q.push_back({(k == 0) ? 2'b01 : 2'b00, w});
        end
        if (good && (n % 4) != 0) begin
            w = 32'h0;
            for (int b = 0; b < n % 4; b++) w[8*b +: 8] = fb[4*full+b];
            exp_q.push_back({(full == 0) ? 2'b01 : 2'b00, w});
        end
        if (good) exp_q.push_back({2'b10, st, 16'(n)});
        else      exp_q.push_back({2'b11, 16'h0000, 16'(n)});
    endtask

    task automatic send_frame(input int n, input bit good, input bit end_on_last, input bit gaps);
        rxStart = 1'b1;
        step();
        rxStart = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) step();
            rxDataValid = 1'b1;
            rxData      = fb[i];
            if (good && end_on_last && i == n - 1) begin
                rxEnd    = 1'b1;
                rxStatus = cur_status;
            end
            step();
            rxDataValid = 1'b0;
            rxEnd       = 1'b0;
        end
        if (!(good && end_on_last && n > 0)) begin
            if (good) begin
                rxEnd    = 1'b1;
                rxStatus = cur_status;
            end else begin
                rxAbort = 1'b1;
            end
            step();
            rxEnd   = 1'b0;
            rxAbort = 1'b0;
        end
    endtask

    task automatic flush_pulse();
        wrFlush = 1'b1;
        step();
        wrFlush = 1'b0;
        got_q.delete();
    endtask

    initial begin
        int  n;
        bit  good;
        bit  eol;

        // Reset state
        repeat (3) @(posedge wrClk);
        @(negedge wrClk);
        chk("rst_write", 64'(fifoWrite), 64'd0);
        chk("rst_data", 64'(fifoWrData), 64'd0);
        chk("rst_tag", 64'(fifoWrTag), 64'd0);
        chk("rst_busy", 64'(rxBusy), 64'd0);
        chk("rst_ovf", 64'(rxOverflow), 64'd0);
        chk("rst_drop", 64'(rxDropCnt), 64'd0);
        wrHardReset_n = 1'b1;
        step();

        // 1: six bytes, END on the last byte
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44; fb[4] = 8'h55; fb[5] = 8'h66;
        cur_status = 16'hA5C3;
        send_frame(6, 1'b1, 1'b1, 1'b0);
        wait_idle("t1");
        exp_q.push_back({2'b01, 32'h44332211});
        exp_q.push_back({2'b00, 32'h00006655});
        exp_q.push_back({2'b10, 16'hA5C3, 16'h0006});
        cmp_q("t1");

        // 2: three-byte frame
        fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC;
        cur_status = 16'h1234;
        send_frame(3, 1'b1, 1'b1, 1'b1);
        wait_idle("t2");
        exp_q.push_back({2'b01, 32'h00CCBBAA});
        exp_q.push_back({2'b10, 16'h1234, 16'h0003});
        cmp_q("t2");

        // 3: FIFO full through an 8-byte frame, released two cycles after rxEnd
        for (int i = 0; i < 8; i++) fb[i] = 8'(8'h30 + i);
        cur_status = 16'hBEEF;
        fifoFull = 1'b1;
        send_frame(8, 1'b1, 1'b1, 1'b0);
        step();
        step();
        fifoFull = 1'b0;
        wait_idle("t3");
        exp_q.push_back({2'b01, 32'h33323130});
        exp_q.push_back({2'b11, 16'h0000, 16'h0008});
        cmp_q("t3");
        chk("t3_ovf", 64'(rxOverflow), 64'd1);
        chk("t3_drop", 64'(rxDropCnt), 64'd1);

        // 5: flush mid-frame clears everything, stray bytes ignored afterwards
        rxStart = 1'b1;
        step();
        rxStart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rxDataValid = 1'b1;
            rxData      = 8'(8'h70 + i);
            step();
        end
        rxDataValid = 1'b0;
        wrFlush = 1'b1;
        step();
        wrFlush = 1'b0;
        @(negedge wrClk);
        chk("t5_write", 64'(fifoWrite), 64'd0);
        chk("t5_busy", 64'(rxBusy), 64'd0);
        chk("t5_ovf", 64'(rxOverflow), 64'd0);
        chk("t5_drop", 64'(rxDropCnt), 64'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            rxDataValid = 1'b1;
            rxData      = 8'(i);
            rxEnd       = (i == 5);
            step();
        end
        rxDataValid = 1'b0;
        rxEnd       = 1'b0;
        step();
        chk("t5_stray_busy", 64'(rxBusy), 64'd0);
        cmp_q("t5");

        // 4: abort after five bytes
        for (int i = 0; i < 5; i++) fb[i] = 8'(8'hC0 + i);
        send_frame(5, 1'b0, 1'b0, 1'b1);
        wait_idle("t4");
        exp_q.push_back({2'b01, 32'hC3C2C1C0});
        exp_q.push_back({2'b11, 16'h0000, 16'h0005});
        cmp_q("t4");
        chk("t4_ovf", 64'(rxOverflow), 64'd0);
        chk("t4_drop", 64'(rxDropCnt), 64'd1);

        // 6: END word held under fifoFull; a second rxStart during the hold is lost
        flush_pulse();
        for (int i = 0; i < 4; i++) fb[i] = 8'(8'hE0 + i);
        cur_status = 16'h5A5A;
        send_frame(4, 1'b1, 1'b0, 1'b0);
        fifoFull = 1'b1;
        step();
        @(negedge wrClk);
        chk("t6_hold0_wr", 64'(fifoWrite), 64'd0);
        chk("t6_hold0", 64'({fifoWrTag, fifoWrData}), 64'({2'b10, 16'h5A5A, 16'h0004}));
        rxStart = 1'b1;
        step();
        rxStart = 1'b0;
        @(negedge wrClk);
        chk("t6_hold1_wr", 64'(fifoWrite), 64'd0);
        chk("t6_hold1", 64'({fifoWrTag, fifoWrData}), 64'({2'b10, 16'h5A5A, 16'h0004}));
        step();
        fifoFull = 1'b0;
        @(negedge wrClk);
        chk("t6_release_wr", 64'(fifoWrite), 64'd1);
        step();
        chk("t6_busy", 64'(rxBusy), 64'd0);
        chk("t6_drop", 64'(rxDropCnt), 64'd1);
        exp_q.push_back({2'b01, 32'hE3E2E1E0});
        exp_q.push_back({2'b10, 16'h5A5A, 16'h0004});
        cmp_q("t6");
        exp_drop = 1;

        // Randomized frames against the model
        rnd_full = 1'b1;
        for (int f = 0; f < 40; f++) begin
            n    = $urandom_range(0, 11);
            good = ($urandom_range(0, 3) != 0);
            eol  = $urandom_range(0, 1) == 1;
            cur_status = 16'($urandom);
            for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
            send_frame(n, good, eol, 1'b1);
            wait_idle($sformatf("r%0d", f));
            build_expected(n, good, cur_status);
            if (!good) exp_drop++;
            cmp_q($sformatf("r%0d", f));
            chk($sformatf("r%0d_drop", f), 64'(rxDropCnt), 64'(exp_drop));
            chk($sformatf("r%0d_ovf", f), 64'(rxOverflow), 64'd0);
        end
        rnd_full = 1'b0;
        step();
        fifoFull = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
